// File: rtl/ann_img_loader_if.sv
// Stream-in, frame-status and random-read signals of the ANN image loader.
// The master side drives pixels and read requests; the slave side is the loader.
interface ann_img_loader_if #(
    parameter int PIX_W  = 20,
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [PIX_W-1:0]  s_data;
    logic              s_last;
    logic              frm_valid;
    logic              frm_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;
    logic              frm_release;
    logic              err_len;
    logic [15:0]       frm_count;

    modport master (
        output s_valid, s_data, s_last, rd_addr, frm_release,
        input  s_ready, frm_valid, frm_bank, rd_data, err_len, frm_count
    );

    modport slave (
        input  s_valid, s_data, s_last, rd_addr, frm_release,
        output s_ready, frm_valid, frm_bank, rd_data, err_len, frm_count
    );
endinterface

// File: rtl/ann_img_loader.sv
// Streaming image loader: saturates pixels, fills a two-bank ping-pong frame buffer,
// and presents the oldest complete frame through a registered random read port.
module ann_img_loader #(
    parameter int PIX_W   = 20,
    parameter int NPIX    = 784,
    parameter int SAT_MAX = 1023,
    parameter int ADDR_W  = $clog2(NPIX)
) (
    input logic              clk,
    input logic              rst_n,
    ann_img_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, FILL, DROP} state_e;

    localparam logic [PIX_W-1:0]  SAT_V  = PIX_W'(SAT_MAX);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   NPIX_V = (ADDR_W + 1)'(NPIX);

    state_e            state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        full_q, full_d;
    logic              rd_bank_q, rd_bank_d;
    logic              s_ready_q, s_ready_d;
    logic              err_len_q, err_len_d;
    logic [15:0]       frm_count_q, frm_count_d;
    logic [PIX_W-1:0]  rd_data_q, rd_data_d;

    logic [PIX_W-1:0]  mem [2][NPIX];

    logic              beat;
    logic              wr_en;
    logic [PIX_W-1:0]  pix_sat;

    assign beat    = bus.s_valid & s_ready_q;
    assign wr_en   = beat && (state_q != DROP);
    assign pix_sat = (bus.s_data > SAT_V) ? SAT_V : bus.s_data;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        full_d      = full_q;
        rd_bank_d   = rd_bank_q;
        err_len_d   = 1'b0;
        frm_count_d = frm_count_q;

        // Release and write completion always target different banks, so both may land together.
        if (bus.frm_release && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (beat) begin
            case (state_q)
                IDLE, FILL: begin
                    state_d   = FILL;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == LAST_A) begin
                        wr_addr_d = '0;
                        if (bus.s_last) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            frm_count_d       = frm_count_q + 16'd1;
                            state_d           = IDLE;
                        end else begin
                            err_len_d = 1'b1;
                            state_d   = DROP;
                        end
                    end else if (bus.s_last) begin
                        err_len_d = 1'b1;
                        wr_addr_d = '0;
                        state_d   = IDLE;
                    end
                end
                DROP: begin
                    if (bus.s_last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // Ready is registered from next-state values so it never admits a beat into a full bank.
        s_ready_d = (state_d == DROP) || !full_d[wr_bank_d];

        rd_data_d = '0;
        if ({1'b0, bus.rd_addr} < NPIX_V) rd_data_d = mem[rd_bank_q][bus.rd_addr];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            full_q      <= '0;
            rd_bank_q   <= 1'b0;
            s_ready_q   <= 1'b0;
            err_len_q   <= 1'b0;
            frm_count_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            full_q      <= full_d;
            rd_bank_q   <= rd_bank_d;
            s_ready_q   <= s_ready_d;
            err_len_q   <= err_len_d;
            frm_count_q <= frm_count_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // NOTE: the frame store has no reset; contents are only meaningful once a full frame lands.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_bank_q][wr_addr_q] <= pix_sat;
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.frm_valid = full_q[rd_bank_q];
    assign bus.frm_bank  = rd_bank_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err_len   = err_len_q;
    assign bus.frm_count = frm_count_q;
endmodule

// File: tb/tb_ann_img_loader.sv
// Self-checking bench for ann_img_loader: directed scenarios plus randomized frames,
// checked against a frame-queue model (completed vs released frame counts).
module tb_ann_img_loader;
    localparam int PIX_W  = 20;
    localparam int NPIX   = 784;
    localparam int SAT    = 1023;
    localparam int ADDR_W = 10;

    logic clk;
    logic rst_n;

    ann_img_loader_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

    ann_img_loader #(.PIX_W(PIX_W), .NPIX(NPIX), .SAT_MAX(SAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs;
    int errs;
    int done_cnt;
    int rel_cnt;
    logic [PIX_W-1:0] bank_img [2][NPIX];
    logic [PIX_W-1:0] cur_pix  [0:1023];

    function automatic logic [PIX_W-1:0] sat(input logic [PIX_W-1:0] d);
        return (d > PIX_W'(SAT)) ? PIX_W'(SAT) : d;
    endfunction

    function automatic logic [PIX_W-1:0] rnd_pix();
        if ($urandom_range(0, 1) == 0) return PIX_W'($urandom_range(0, 1100));
        return PIX_W'($urandom());
    endfunction

    task automatic check_status(input string tag);
        logic exp_v, exp_b, exp_r;
        logic [15:0] exp_c;
        exp_v = (done_cnt - rel_cnt) > 0;
        exp_b = (rel_cnt % 2) == 1;
        exp_r = (done_cnt - rel_cnt) < 2;
        exp_c = 16'(done_cnt);
        vecs += 4;
        if (bus.frm_valid !== exp_v) begin
            errs++; $display("FAIL %s frm_valid: got %b want %b", tag, bus.frm_valid, exp_v);
        end
        if (bus.frm_bank !== exp_b) begin
            errs++; $display("FAIL %s frm_bank: got %b want %b", tag, bus.frm_bank, exp_b);
        end
        if (bus.s_ready !== exp_r) begin
            errs++; $display("FAIL %s s_ready: got %b want %b", tag, bus.s_ready, exp_r);
        end
        if (bus.frm_count !== exp_c) begin
            errs++; $display("FAIL %s frm_count: got %0d want %0d", tag, bus.frm_count, exp_c);
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic push(input logic [PIX_W-1:0] d, input bit last, input bit rel_req, input bit exp_err);
        int  t;
        bit  took;
        bus.s_valid     = 1'b1;
        bus.s_data      = d;
        bus.s_last      = last;
        bus.frm_release = rel_req;
        took = 1'b0;
        t    = 0;
        while (!took && t < 300) begin
            took = bus.s_ready;
            @(posedge clk);
            #1;
            bus.frm_release = 1'b0;
            if (!took) @(negedge clk);
            t++;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge clk);
        vecs++;
        if (!took) begin
            errs++; $display("FAIL push_timeout: s_ready stayed %b, want 1 within 300 cycles", bus.s_ready);
        end else if (bus.err_len !== exp_err) begin
            errs++; $display("FAIL err_len: got %b want %b (last=%b)", bus.err_len, exp_err, last);
        end
    endtask

    task automatic send_frame(input int len, input bit rel_on_last, input string tag);
        int exp_err_at;
        int last_at;
        last_at    = len - 1;
        exp_err_at = (last_at < NPIX - 1) ? last_at : ((last_at > NPIX - 1) ? NPIX - 1 : -1);
        for (int k = 0; k < len; k++) begin
            bit r;
            r = rel_on_last && (k == last_at);
            if (r && (done_cnt - rel_cnt) > 0) rel_cnt++;
            push(cur_pix[k], k == last_at, r, k == exp_err_at);
        end
        if (len == NPIX) begin
            for (int k = 0; k < NPIX; k++) bank_img[done_cnt % 2][k] = sat(cur_pix[k]);
            done_cnt++;
        end
        check_status(tag);
    endtask

    task automatic check_read(input int addr);
        logic [PIX_W-1:0] exp_d;
        bus.rd_addr = ADDR_W'(addr);
        @(posedge clk);
        @(negedge clk);
        exp_d = (addr >= NPIX) ? '0 : bank_img[rel_cnt % 2][addr];
        vecs++;
        if (bus.rd_data !== exp_d) begin
            errs++; $display("FAIL read[%0d]: got %0d want %0d", addr, bus.rd_data, exp_d);
        end
    endtask

    task automatic release_frame(input string tag);
        bus.frm_release = 1'b1;
        if ((done_cnt - rel_cnt) > 0) rel_cnt++;
        @(posedge clk);
        #1;
        bus.frm_release = 1'b0;
        @(negedge clk);
        check_status(tag);
    endtask

    task automatic test_reset();
        bus.s_valid     = 1'b0;
        bus.s_last      = 1'b0;
        bus.frm_release = 1'b0;
        rst_n = 1'b0;
        #1;
        vecs += 6;
        if (bus.s_ready !== 1'b0)    begin errs++; $display("FAIL rst s_ready: got %b want 0", bus.s_ready); end
        if (bus.frm_valid !== 1'b0)  begin errs++; $display("FAIL rst frm_valid: got %b want 0", bus.frm_valid); end
        if (bus.frm_bank !== 1'b0)   begin errs++; $display("FAIL rst frm_bank: got %b want 0", bus.frm_bank); end
        if (bus.rd_data !== '0)      begin errs++; $display("FAIL rst rd_data: got %0d want 0", bus.rd_data); end
        if (bus.err_len !== 1'b0)    begin errs++; $display("FAIL rst err_len: got %b want 0", bus.err_len); end
        if (bus.frm_count !== 16'd0) begin errs++; $display("FAIL rst frm_count: got %0d want 0", bus.frm_count); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        rel_cnt  = 0;
        @(negedge clk);
        @(negedge clk);
        check_status("post_reset");
    endtask

    task automatic test_basic_frame();
        test_reset();
        for (int k = 0; k < NPIX; k++) cur_pix[k] = PIX_W'(k);
        send_frame(NPIX, 1'b0, "basic");
        check_read(153);
        check_read(0);
        check_read(NPIX - 1);
        check_read(800);
        check_read(1023);
    endtask

    task automatic test_saturation();
        test_reset();
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        cur_pix[10] = 20'd1024;
        cur_pix[11] = 20'hFFFFF;
        cur_pix[12] = 20'd1019;
        cur_pix[13] = 20'd1023;
        cur_pix[14] = 20'd0;
        send_frame(NPIX, 1'b0, "saturation");
        for (int a = 10; a <= 14; a++) check_read(a);
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
            send_frame(NPIX, 1'b0, "b2b_fill");
        end
        bus.s_valid = 1'b1;
        bus.s_data  = rnd_pix();
        repeat (5) @(negedge clk);
        check_status("b2b_backpressure");
        bus.s_valid = 1'b0;
        check_read(321);
        release_frame("b2b_release");
        check_read(321);
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        send_frame(NPIX, 1'b1, "b2b_simul");
        check_read(5);
        check_read(700);
    endtask

    task automatic test_short_frame();
        test_reset();
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        send_frame(101, 1'b0, "short");
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        send_frame(NPIX, 1'b0, "after_short");
        check_read(50);
        check_read(600);
    endtask

    task automatic test_long_frame();
        test_reset();
        for (int k = 0; k < 1024; k++) cur_pix[k] = rnd_pix();
        send_frame(NPIX + 1, 1'b0, "long");
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        send_frame(NPIX, 1'b0, "after_long");
        check_read(783);
        check_read(1);
    endtask

    task automatic test_reset_mid_frame();
        test_reset();
        for (int k = 0; k < 400; k++) push(rnd_pix(), 1'b0, 1'b0, 1'b0);
        test_reset();
        for (int k = 0; k < NPIX; k++) cur_pix[k] = rnd_pix();
        send_frame(NPIX, 1'b0, "after_mid_reset");
        check_read(399);
        check_read(400);
    endtask

    task automatic test_random();
        test_reset();
        for (int it = 0; it < 12; it++) begin
            int kind;
            int len;
            if ((done_cnt - rel_cnt) == 2) release_frame("rnd_free");
            kind = $urandom_range(0, 9);
            if (kind == 0)      len = $urandom_range(1, NPIX - 1);
            else if (kind == 1) len = $urandom_range(NPIX + 1, NPIX + 20);
            else                len = NPIX;
            for (int k = 0; k < len; k++) cur_pix[k] = rnd_pix();
            send_frame(len, $urandom_range(0, 1) == 1, "rnd_frame");
            if ((done_cnt - rel_cnt) > 0) begin
                for (int r = 0; r < 3; r++) check_read($urandom_range(0, NPIX - 1));
                check_read($urandom_range(NPIX, 1023));
            end
            if ($urandom_range(0, 2) == 0) release_frame("rnd_release");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs     = 0;
        errs     = 0;
        done_cnt = 0;
        rel_cnt  = 0;
        rst_n           = 1'b0;
        bus.s_valid     = 1'b0;
        bus.s_data      = '0;
        bus.s_last      = 1'b0;
        bus.rd_addr     = '0;
        bus.frm_release = 1'b0;
        @(negedge clk);
        test_basic_frame();
        test_saturation();
        test_back_to_back();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
